store_data_packer: RTL and testbench
====================================

// Module: store_data_packer
// PURPOSE
//  Store-side counterpart of the load/immediate extension path: takes a 32-bit register value
//  from EX/MEM, narrows it to byte/half/word, lane-replicates it and generates byte enables.
//  Packed stores are buffered in a small FIFO and drained to data memory over a valid/ready
//  handshake, decoupling the pipeline from memory wait states.
// PARAMETERS
//  DEPTH  2   FIFO entries (power of two, >=2)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  flush         in   1   synchronous FIFO clear (pipeline flush)
//  st_valid      in   1   store request valid
//  st_ready      out  1   buffer can accept (= !full)
//  st_addr       in   32  byte address
//  st_data       in   32  register value (source rt)
//  st_size       in   2   00 byte, 01 half, 10 word, 11 treated as word
//  mem_valid     out  1   head entry valid (= !empty)
//  mem_ready     in   1   memory accepts head entry
//  mem_addr      out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wdata     out  32  lane-replicated data
//  mem_be        out  4   byte enables
//  misalign      out  1   1-cycle pulse, misaligned store dropped (MISALIGN_TRAP_EN only)
//  misalign_addr out  32  address of last dropped store
//  count         out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset: FIFO empty, pointers/count 0, mem_valid 0, mem_addr/mem_wdata/mem_be 0,
//    misalign 0, misalign_addr 0. Reset mid-drain discards all entries immediately.
//  - Push on st_valid&&st_ready; pop on mem_valid&&mem_ready. Push+pop same cycle: count holds.
//  - st_ready = !full (no pass-through when full). Latency accept->mem_valid = 1 cycle.
//  - Head outputs stable while mem_valid && !mem_ready; zero when empty.
//  - Packing (at push): byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0];
//    half: wdata={2{d[15:0]}}, be=addr[1]?4'b1100:4'b0011; word: wdata=d, be=4'b1111.
//  - Misaligned: half with addr[0]=1; word/11 with addr[1:0]!=0.
//  - flush: empties FIFO next edge; priority flush > push/pop; st_ready still = !full that cycle,
//    a request accepted in a flush cycle is discarded.
//  - Pointers wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: misaligned stores are accepted (handshake completes) but not
//   enqueued; misalign pulses high the following cycle, misalign_addr captures st_addr.
//  Not defined: misalign tied 0, misalign_addr tied 0; misaligned stores enqueued with low
//   address bits ignored (half uses addr[1] only, word uses none).
// STRUCTURE
//  cpu_pkg: SZ_BYTE/SZ_HALF/SZ_WORD localparams, store-entry struct {addr[31:2], wdata, be}.
//  Sub-module store_fifo (generic DEPTH x entry, push/pop/flush, full/empty/count);
//  packing + misalign check combinational in top.
// TESTING
//  1 byte store addr 0x1003 data 0xAABBCCDD, mem_ready=1 -> next cycle mem_addr 0x1000,
//    wdata 0xDDDDDDDD, be 4'b1000.
//  2 half store addr 0x2002 data 0x12345678 -> wdata 0x56785678, be 4'b1100; word to 0x2004 -> be 4'b1111.
//  3 mem_ready=0, push 3 stores (DEPTH=2) -> st_ready low after 2, count=2; mem_ready=1 ->
//    drains in order, simultaneous push/pop holds count.
//  4 word store addr 0x3001: with MISALIGN_TRAP_EN -> misalign pulse, misalign_addr 0x3001,
//    count unchanged; without -> entry mem_addr 0x3000, be 4'b1111.
//  5 FIFO with 2 entries, assert flush (and st_valid) -> next cycle count 0, mem_valid 0;
//    assert rst asynchronously mid-drain -> mem_valid drops immediately, all outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared store-path types: access-size codes and the buffered store entry.
package cpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_entry_t;

  localparam int ST_ENTRY_W = $bits(st_entry_t);

endpackage

// File: rtl/store_fifo.sv
// Generic DEPTH x W synchronous FIFO with flush; flush beats push/pop.
module store_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/store_data_packer.sv
// Store narrowing, lane replication and byte enables, buffered to memory.
// Optional MISALIGN_TRAP_EN drops misaligned stores and reports them.
module store_data_packer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic                     misalign,
  output logic [31:0]              misalign_addr,
  output logic [$clog2(DEPTH):0]   count
);

  st_entry_t ent;
  st_entry_t head;
  logic      full;
  logic      empty;
  logic      accept;
  logic      push;
  logic [1:0] lo;

  assign lo     = st_addr[1:0];
  assign accept = st_valid && st_ready;

  always_comb begin
    ent.addr  = st_addr[31:2];
    ent.wdata = st_data;
    ent.be    = 4'b1111;
    unique case (1'b1)
      (st_size == SZ_BYTE): begin
        ent.wdata = {4{st_data[7:0]}};
        ent.be    = 4'b0001 << lo;
      end
      (st_size == SZ_HALF): begin
        ent.wdata = {2{st_data[15:0]}};
        ent.be    = lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis;

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      (st_size == SZ_BYTE): mis = 1'b0;
      (st_size == SZ_HALF): mis = lo[0];
      default:              mis = (lo != 2'b00);
    endcase
  end

  assign push = accept && !mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= accept && mis;
      if (accept && mis)
        misalign_addr <= st_addr;
    end
  end
`else
  assign push          = accept;
  assign misalign      = 1'b0;
  assign misalign_addr = '0;
`endif

  store_fifo #(
    .DEPTH (DEPTH),
    .W     (ST_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (ent),
    .pop   (mem_valid && mem_ready),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign st_ready  = !full;
  assign mem_valid = !empty;
  // Head is masked so an empty buffer presents all-zero outputs.
  assign mem_addr  = mem_valid ? {head.addr, 2'b00} : '0;
  assign mem_wdata = mem_valid ? head.wdata : '0;
  assign mem_be    = mem_valid ? head.be : '0;

endmodule

// File: tb/tb_store_data_packer.sv
// Directed bench for store_data_packer (DEPTH=2).
module tb_store_data_packer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [1:0]  count;

  int total;
  int bad;

  store_data_packer #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_size       (st_size),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s);
    @(negedge clk);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b);
    chk({tag, ".v"}, 32'(mem_valid), 32'd1);
    chk({tag, ".a"}, mem_addr, a);
    chk({tag, ".d"}, mem_wdata, d);
    chk({tag, ".be"}, 32'(mem_be), 32'(b));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_size   = 2'b00;
    mem_ready = 1'b0;
    #12;
    chk("rst.valid", 32'(mem_valid), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.be", 32'(mem_be), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.mis", 32'(misalign), 32'd0);
    chk("rst.misaddr", misalign_addr, 32'd0);
    chk("rst.ready", 32'(st_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // byte into top lane
    mem_ready = 1'b1;
    drive(1'b1, 32'h0000_1003, 32'hAABB_CCDD, 2'b00);
    step();
    head("byte3", 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    step();
    chk("byte3.drain", 32'(count), 32'd0);

    // byte lane 0, half upper, half lower, word (back-to-back with pop)
    drive(1'b1, 32'h0000_0040, 32'h0000_00A5, 2'b00);
    step();
    head("byte0", 32'h0000_0040, 32'hA5A5_A5A5, 4'b0001);
    drive(1'b1, 32'h0000_2002, 32'h1234_5678, 2'b01);
    step();
    head("halfhi", 32'h0000_2000, 32'h5678_5678, 4'b1100);
    drive(1'b1, 32'h0000_2000, 32'h1234_9ABC, 2'b01);
    step();
    head("halflo", 32'h0000_2000, 32'h9ABC_9ABC, 4'b0011);
    drive(1'b1, 32'h0000_2004, 32'h1234_5678, 2'b10);
    step();
    head("word", 32'h0000_2004, 32'h1234_5678, 4'b1111);
    drive(1'b1, 32'h0000_2008, 32'hDEAD_BEEF, 2'b11);
    step();
    head("size11", 32'h0000_2008, 32'hDEAD_BEEF, 4'b1111);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    step();
    chk("t2.drain", 32'(count), 32'd0);

    // fill with memory stalled, third request held back
    @(negedge clk);
    mem_ready = 1'b0;
    drive(1'b1, 32'h0000_0100, 32'h1111_1111, 2'b10);
    step();
    drive(1'b1, 32'h0000_0104, 32'h2222_2222, 2'b10);
    step();
    drive(1'b1, 32'h0000_0108, 32'h3333_3333, 2'b10);
    step();
    chk("full.count", 32'(count), 32'd2);
    chk("full.ready", 32'(st_ready), 32'd0);
    head("full.hold", 32'h0000_0100, 32'h1111_1111, 4'b1111);
    @(negedge clk);
    mem_ready = 1'b1;
    step();
    chk("pop1.count", 32'(count), 32'd1);
    head("pop1", 32'h0000_0104, 32'h2222_2222, 4'b1111);
    step();
    chk("pushpop.count", 32'(count), 32'd1);
    head("pop2", 32'h0000_0108, 32'h3333_3333, 4'b1111);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    step();
    chk("t3.drain", 32'(count), 32'd0);
    chk("t3.valid", 32'(mem_valid), 32'd0);

    // misaligned word
    @(negedge clk);
    mem_ready = 1'b0;
    drive(1'b1, 32'h0000_3001, 32'hCAFE_BABE, 2'b10);
    step();
`ifdef MISALIGN_TRAP_EN
    chk("mis.pulse", 32'(misalign), 32'd1);
    chk("mis.addr", misalign_addr, 32'h0000_3001);
    chk("mis.count", 32'(count), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    step();
    chk("mis.fall", 32'(misalign), 32'd0);
    chk("mis.keep", misalign_addr, 32'h0000_3001);
`else
    chk("mis.none", 32'(misalign), 32'd0);
    chk("mis.count", 32'(count), 32'd1);
    head("mis.word", 32'h0000_3000, 32'hCAFE_BABE, 4'b1111);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    mem_ready = 1'b1;
    step();
    chk("mis.drain", 32'(count), 32'd0);
`endif

    // flush a full buffer while a request is offered
    @(negedge clk);
    mem_ready = 1'b0;
    drive(1'b1, 32'h0000_0200, 32'h4444_4444, 2'b10);
    step();
    drive(1'b1, 32'h0000_0204, 32'h5555_5555, 2'b10);
    step();
    chk("fl.pre", 32'(count), 32'd2);
    drive(1'b1, 32'h0000_0208, 32'h6666_6666, 2'b10);
    flush = 1'b1;
    step();
    chk("fl.count", 32'(count), 32'd0);
    chk("fl.valid", 32'(mem_valid), 32'd0);
    // request accepted during flush is discarded
    step();
    chk("fl.acc", 32'(count), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    st_valid = 1'b0;

    // async reset mid-drain
    drive(1'b1, 32'h0000_0300, 32'h7777_7777, 2'b10);
    step();
    drive(1'b1, 32'h0000_0304, 32'h8888_8888, 2'b10);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    mem_ready = 1'b1;
    step();
    head("rd.mid", 32'h0000_0304, 32'h8888_8888, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.valid", 32'(mem_valid), 32'd0);
    chk("ar.addr", mem_addr, 32'd0);
    chk("ar.wdata", mem_wdata, 32'd0);
    chk("ar.be", 32'(mem_be), 32'd0);
    chk("ar.count", 32'(count), 32'd0);
    chk("ar.misaddr", misalign_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("ar.after", 32'(mem_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
